uart_rx_fifo: RTL and testbench

Oversampling UART receiver, parametrised successor to the single-buffer receiver.
- Adds 3-sample majority voting, runtime-selectable parity and stop-bit count, false-start rejection, break detection, per-word error tagging, and a small output FIFO with sticky overflow.
- Sits between the pad synchroniser domain and a byte-stream consumer (command parser, DMA) using a valid/ready handshake.

---
 rtl/uart_rx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with 3-sample voting,
// runtime parity/stop selection, break detection and an output FIFO.
module uart_rx_fifo #(
  parameter int w     = 8,
  parameter int ss    = 16,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic                     rxd,
  input  logic                     strobe,
  input  logic [1:0]               parity_mode,
  input  logic                     stop2,
  output logic [w-1:0]             data,
  output logic                     frame_error,
  output logic                     parity_error,
  output logic                     break_det,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(depth):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr
);
  localparam int M  = (ss + 1) / 2 - 1;
  localparam int CW = $clog2(ss);
  localparam int BW = $clog2(w);
  localparam int AW = $clog2(depth);
  localparam int EW = w + 3;

  localparam logic [CW-1:0] C_LAST = CW'(ss - 1);
  localparam logic [CW-1:0] C_S0   = CW'(M - 1);
  localparam logic [CW-1:0] C_S1   = CW'(M);
  localparam logic [CW-1:0] C_S2   = CW'(M + 1);
  localparam logic [CW-1:0] C_PUSH = CW'(M + 2);
  localparam logic [BW-1:0] B_LAST = BW'(w - 1);
  localparam logic [AW:0]   NFULL  = (AW + 1)'(depth);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRKWAIT
  } state_t;

  state_t state, state_n;

  logic          s1, rxs;
  logic          tick;
  logic [CW-1:0] cnt;
  logic [1:0]    smp;
  logic          vote, maj;
  logic [w-1:0]  sh;
  logic [BW-1:0] bidx;
  logic          sidx;
  logic [1:0]    pm;
  logic          two;
  logic          perr, ferr, allz;
  logic          par_en, bit_end, push_pt;
  logic          brk_w, ferr_w, push;
  logic [EW-1:0] wword;

  logic [EW-1:0] mem [depth];
  logic [AW:0]   wp, rp;
  logic          full, pop, wen;
  logic [EW-1:0] head;

  assign tick    = clken & strobe;
  assign maj     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign par_en  = pm[0] ^ pm[1];
  assign bit_end = tick & (cnt == C_LAST);
  assign push_pt = tick & (cnt == C_PUSH) & (sidx == two);
  assign brk_w   = allz & ~vote;
  assign ferr_w  = ferr | ~vote;
  assign wword   = {brk_w, perr, ferr_w, sh & {w{~brk_w}}};

  always_comb begin
    state_n = state;
    push    = 1'b0;
    unique case (state)
      IDLE:    if (tick && !rxs) state_n = START;
      START:   if (bit_end) state_n = vote ? IDLE : DATA;
      DATA:    if (bit_end && bidx == B_LAST)
                 state_n = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (push_pt) begin
                 push    = 1'b1;
                 state_n = brk_w ? BRKWAIT : IDLE;
               end
      BRKWAIT: if (tick && rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1    <= 1'b1;
      rxs   <= 1'b1;
      cnt   <= '0;
      smp   <= '0;
      vote  <= 1'b0;
      sh    <= '0;
      bidx  <= '0;
      sidx  <= 1'b0;
      pm    <= '0;
      two   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      allz  <= 1'b0;
    end else if (clken) begin
      s1    <= rxd;
      rxs   <= s1;
      state <= state_n;
      if (tick) begin
        if (state == IDLE) begin
          cnt  <= '0;
          bidx <= '0;
          sidx <= 1'b0;
          perr <= 1'b0;
          ferr <= 1'b0;
          allz <= 1'b1;
          pm   <= parity_mode;
          two  <= stop2;
        end else begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
        end
        if (cnt == C_S0) smp[0] <= rxs;
        if (cnt == C_S1) smp[1] <= rxs;
        if (cnt == C_S2) vote <= maj;
        if (bit_end) begin
          unique case (state)
            DATA: begin
              sh   <= {vote, sh[w-1:1]};
              bidx <= bidx + 1'b1;
              allz <= allz & ~vote;
            end
            PARITY: begin
              perr <= (^sh) ^ vote ^ pm[1];
              allz <= allz & ~vote;
            end
            STOP: begin
              ferr <= ferr | ~vote;
              allz <= allz & ~vote;
              sidx <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // full FIFO accepts a push only when the head leaves in the same cycle
  assign level = wp - rp;
  assign valid = (wp != rp);
  assign full  = (level == NFULL);
  assign pop   = clken & valid & ready;
  assign wen   = push & (~full | pop);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wen) mem[wp[AW-1:0]] <= wword;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else if (clken) begin
      if (wen) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && !wen) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign data         = valid ? head[w-1:0] : '0;
  assign frame_error  = valid & head[w];
  assign parity_error = valid & head[w+1];
  assign break_det    = valid & head[w+2];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: tick-accurate serial line driver,
// word-level expected queue and a per-cycle output compare.
module tb_uart_rx_fifo;
  localparam int W  = 8;
  localparam int SS = 16;
  localparam int D  = 4;
  localparam int M  = (SS + 1) / 2 - 1;
  localparam int PUSH_EDGE = 3 + SS * (W + 1) + M + 2;

  typedef logic [W+2:0] word_t;

  logic clk = 1'b0;
  logic rst, clken, rxd, strobe, stop2, ready, overflow_clr;
  logic [1:0] parity_mode;
  logic [W-1:0] data;
  logic frame_error, parity_error, break_det, valid, overflow;
  logic [$clog2(D):0] level;

  word_t q[$];
  word_t last_pop;
  int checks = 0;
  int failures = 0;
  int ticks = 0;
  int cyc = 0;
  int vcount = 0;
  bit det = 1'b0;
  bit exp_ovf = 1'b0;

  uart_rx_fifo #(.w(W), .ss(SS), .depth(D)) dut (
    .clk(clk), .rst(rst), .clken(clken), .rxd(rxd),
    .strobe(strobe), .parity_mode(parity_mode), .stop2(stop2),
    .data(data), .frame_error(frame_error),
    .parity_error(parity_error), .break_det(break_det),
    .valid(valid), .ready(ready), .level(level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clken && strobe) ticks <= ticks + 1;
  end

  initial begin
    clken = 1'b1;
    strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (det) begin
        clken = 1'b1;
        strobe = 1'b1;
      end else begin
        clken = ($urandom_range(7) != 0);
        strobe = 1'($urandom_range(1));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    word_t aw, ew;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        aw = {break_det, parity_error, frame_error, data};
        if (valid) vcount++;
        chk("valid_vs_level", 32'(valid), 32'(level != 0));
        if (!valid) chk("idle_zero", 32'(aw), 32'h0);
        if (clken && valid && ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%0h required=none", aw);
          end else begin
            ew = q.pop_front();
            chk("pop_word", 32'(aw), 32'(ew));
          end
          last_pop = aw;
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    int t0, g;
    rxd = v;
    t0 = ticks;
    g = 0;
    while (ticks - t0 < n) begin
      @(negedge clk);
      g++;
      if (g > 20 * n + 100) begin
        $display("FAIL tick_timeout actual=%0d required=%0d", ticks - t0, n);
        $fatal(1, "tick budget expired");
      end
    end
  endtask

  // Expected word derived from what goes on the line
  task automatic send_frame(input logic [W-1:0] d, input logic [1:0] pm,
                            input logic st2, input logic pflip,
                            input logic sbad, input logic simul);
    logic pen, pbit, brk, perr;
    word_t wd;
    pen  = (pm == 2'b01) || (pm == 2'b10);
    pbit = (^d) ^ (pm == 2'b10) ^ pflip;
    brk  = (d == '0) && (!pen || !pbit) && sbad && !st2;
    perr = pen && pflip;
    wd   = {brk, perr, sbad, d};
    parity_mode = pm;
    stop2 = st2;
    if (q.size() >= D && !simul) exp_ovf = 1'b1;
    else q.push_back(wd);
    hold(1'b0, SS);
    parity_mode = 2'($urandom_range(3));
    stop2 = 1'($urandom_range(1));
    for (int i = 0; i < W; i++) hold(d[i], SS);
    if (pen) hold(pbit, SS);
    hold(!sbad, SS);
    if (st2) hold(1'b1, SS);
    hold(1'b1, 6);
  endtask

  initial begin
    int v0, start_cyc;
    logic [W-1:0] sp;
    rst = 1'b1;
    rxd = 1'b1;
    ready = 1'b0;
    overflow_clr = 1'b0;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    chk("reset_data", 32'(data), 32'h0);

    det = 1'b1;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    v0 = vcount;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_word", 32'(last_pop), 32'h0A5);
    chk("t1_valid_cycles", 32'(vcount - v0), 32'h1);
    chk("t1_level", 32'(level), 32'h0);

    send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_even_p1", 32'(last_pop), 32'h203);
    send_frame(8'h03, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_even_p0", 32'(last_pop), 32'h003);
    send_frame(8'h03, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_odd_p1", 32'(last_pop), 32'h003);
    send_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_odd_p0", 32'(last_pop), 32'h203);

    v0 = vcount;
    hold(1'b0, 3);
    hold(1'b1, 2 * SS);
    chk("t3_glitch_none", 32'(vcount - v0), 32'h0);
    chk("t3_glitch_level", 32'(level), 32'h0);

    sp = 8'h7E;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    q.push_back({3'b000, sp});
    hold(1'b0, SS);
    for (int i = 0; i < W; i++) begin
      if (i == 1) begin
        hold(1'b1, M + 1);
        hold(1'b0, 1);
        hold(1'b1, SS - M - 2);
      end else begin
        hold(sp[i], SS);
      end
    end
    hold(1'b1, SS + 6);
    chk("t3_spike_word", 32'(last_pop), 32'h07E);

    det = 1'b0;
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_stop_low", 32'(last_pop), 32'h155);
    v0 = vcount;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    q.push_back(word_t'(11'h500));
    hold(1'b0, 30 * SS);
    hold(1'b1, 3 * SS);
    chk("t4_break_word", 32'(last_pop), 32'h500);
    chk("t4_break_once", 32'(vcount - v0), 32'h1);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_after_break", 32'(last_pop), 32'h0C3);

    ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_level_full", 32'(level), 32'h4);
    chk("t5_overflow", 32'(overflow), 32'h1);
    chk("t5_overflow_model", 32'(overflow), 32'(exp_ovf));
    chk("t5_head", 32'(data), 32'h01);
    det = 1'b1;
    repeat (3) @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("t5_ovf_clr", 32'(overflow), 32'h0);
    ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_drained", 32'(level), 32'h0);
    chk("t5_last", 32'(last_pop), 32'h004);

    ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send_frame(8'(8'h10 + i), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_full", 32'(level), 32'h4);
    start_cyc = cyc;
    fork
      send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < PUSH_EDGE + 20; i++) begin
          if (cyc == start_cyc + PUSH_EDGE) break;
          @(negedge clk);
        end
        ready = 1'b1;
        chk("t6_level_before", 32'(level), 32'h4);
        @(negedge clk);
        ready = 1'b0;
        chk("t6_level_after", 32'(level), 32'h4);
        chk("t6_no_overflow", 32'(overflow), 32'h0);
        chk("t6_swap_pop", 32'(last_pop), 32'h011);
      end
    join
    ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_drained", 32'(level), 32'h0);
    chk("t6_last", 32'(last_pop), 32'h015);

    det = 1'b0;
    ready = 1'b0;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t7_pre_level", 32'(level), 32'h1);
    hold(1'b0, SS);
    hold(1'b1, SS);
    hold(1'b0, SS / 2);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    exp_ovf = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t7_valid", 32'(valid), 32'h0);
    chk("t7_level", 32'(level), 32'h0);
    v0 = vcount;
    hold(1'b1, 3 * SS);
    chk("t7_no_push", 32'(vcount - v0), 32'h0);
    chk("t7_level_late", 32'(level), 32'h0);

    ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      send_frame(8'($urandom_range(255)), 2'($urandom_range(3)),
                 1'($urandom_range(1)), ($urandom_range(3) == 0),
                 ($urandom_range(4) == 0), 1'b0);
      hold(1'b1, SS);
    end
    repeat (10) @(negedge clk);
    chk("rand_level", 32'(level), 32'(q.size()));
    chk("rand_overflow", 32'(overflow), 32'(exp_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1, "simulation time budget expired");
  end

endmodule
